// File: rtl/lstm_cell_update_if.sv
// Handshake bundle for the LSTM cell-state update stage:
// gate inputs, tanh side-channel and h/c results.
interface lstm_cell_update_if #(
  parameter int W = 18
);
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] gate_i;
  logic signed [W-1:0] gate_f;
  logic signed [W-1:0] gate_g;
  logic signed [W-1:0] gate_o;
  logic signed [W-1:0] c_old;
  logic                tanh_req;
  logic signed [W-1:0] tanh_operand;
  logic signed [W-1:0] tanh_result;
  logic                tanh_valid;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] h_out;
  logic signed [W-1:0] c_out;
  logic                busy;

  modport master (
    output in_valid, gate_i, gate_f, gate_g, gate_o, c_old,
    output tanh_result, tanh_valid, out_ready,
    input  in_ready, tanh_req, tanh_operand,
    input  out_valid, h_out, c_out, busy
  );

  modport slave (
    input  in_valid, gate_i, gate_f, gate_g, gate_o, c_old,
    input  tanh_result, tanh_valid, out_ready,
    output in_ready, tanh_req, tanh_operand,
    output out_valid, h_out, c_out, busy
  );
endinterface

// File: rtl/lstm_cell_update.sv
// LSTM cell update: c = f*c_old + i*g, h = o*tanh(c), one shared multiplier.
// Define LSTM_CELL_SATURATE_EN to saturate instead of wrap on reduction.
module lstm_cell_update #(
  parameter int QN = 6,
  parameter int QM = 11
) (
  input logic               clk,
  input logic               reset,
  lstm_cell_update_if.slave bus
);
  localparam int W = QN + QM + 1;

  typedef enum logic [2:0] {
    IDLE, MUL_F, MUL_I, TANH_REQ, TANH_WAIT, MUL_O, DONE
  } state_e;

  state_e state_q, state_d;

  logic signed [W-1:0] f_q, c_old_q, i_q, g_q, o_q;
  logic signed [W-1:0] acc_q, c_q, tanh_q;
  logic signed [W-1:0] h_out_q, c_out_q;
  logic signed [W-1:0] mul_a, mul_b, prod_r;
  logic signed [2*W-1:0] prod, prod_sh, sum;

  function automatic logic signed [W-1:0] reduce(
    input logic signed [2*W-1:0] v
  );
`ifdef LSTM_CELL_SATURATE_EN
    logic signed [2*W-1:0] hi, lo;
    hi = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    lo = {{(W+1){1'b1}}, {(W-1){1'b0}}};
    if (v > hi) return W'(hi);
    if (v < lo) return W'(lo);
    return W'(v);
`else
    return W'(v);
`endif
  endfunction

  // operand select for the shared multiplier
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    unique case (state_q)
      MUL_F: begin
        mul_a = f_q;
        mul_b = c_old_q;
      end
      MUL_I: begin
        mul_a = i_q;
        mul_b = g_q;
      end
      MUL_O: begin
        mul_a = o_q;
        mul_b = tanh_q;
      end
      default: ;
    endcase
  end

  assign prod    = mul_a * mul_b;
  assign prod_sh = prod >>> QM;
  assign prod_r  = reduce(prod_sh);
  assign sum     = {{W{acc_q[W-1]}}, acc_q}
                 + {{W{prod_r[W-1]}}, prod_r};

  // state register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (bus.in_valid) state_d = MUL_F;
      MUL_F:     state_d = MUL_I;
      MUL_I:     state_d = TANH_REQ;
      TANH_REQ:  state_d = TANH_WAIT;
      TANH_WAIT: if (bus.tanh_valid) state_d = MUL_O;
      MUL_O:     state_d = DONE;
      DONE:      if (bus.out_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // datapath registers; results latch into output regs on MUL_O
  always_ff @(posedge clk) begin
    if (!reset) begin
      f_q     <= '0;
      c_old_q <= '0;
      i_q     <= '0;
      g_q     <= '0;
      o_q     <= '0;
      acc_q   <= '0;
      c_q     <= '0;
      tanh_q  <= '0;
      h_out_q <= '0;
      c_out_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.in_valid) begin
          f_q     <= bus.gate_f;
          c_old_q <= bus.c_old;
          i_q     <= bus.gate_i;
          g_q     <= bus.gate_g;
          o_q     <= bus.gate_o;
        end
        MUL_F: acc_q <= prod_r;
        MUL_I: c_q <= reduce(sum);
        TANH_WAIT: if (bus.tanh_valid) tanh_q <= bus.tanh_result;
        MUL_O: begin
          h_out_q <= prod_r;
          c_out_q <= c_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready     = (state_q == IDLE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.tanh_req     = (state_q == TANH_REQ);
  assign bus.tanh_operand = c_q;
  assign bus.out_valid    = (state_q == DONE);
  assign bus.h_out        = h_out_q;
  assign bus.c_out        = c_out_q;
endmodule

// File: tb/tb_lstm_cell_update.sv
// Directed + random bench for lstm_cell_update against
// a fixed-point arithmetic reference model.
module tb_lstm_cell_update;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  lstm_cell_update_if bus ();

  lstm_cell_update dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic longint red(longint x);
`ifdef LSTM_CELL_SATURATE_EN
    if (x > 131071) return 131071;
    if (x < -131072) return -131072;
    return x;
`else
    longint m;
    m = x % 262144;
    if (m < 0) m += 262144;
    if (m >= 131072) m -= 262144;
    return m;
`endif
  endfunction

  function automatic longint mulq(longint a, longint b);
    longint p, q;
    p = a * b;
    q = p / 2048;
    if (p < 0 && (p % 2048) != 0) q -= 1;
    return red(q);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic elem(input logic signed [17:0] f,
                      input logic signed [17:0] c,
                      input logic signed [17:0] i,
                      input logic signed [17:0] g,
                      input logic signed [17:0] o,
                      input logic signed [17:0] tv,
                      input int d, input bit early,
                      input int bp);
    longint ce, he;
    int edges, k;
    logic signed [17:0] op;
    ce = red(mulq(f, c) + mulq(i, g));
    he = mulq(o, tv);
    k = 0;
    while (!bus.in_ready && k < 20) begin step(); k++; end
    check("in_ready_idle", bus.in_ready, 1);
    bus.gate_f = f; bus.c_old = c; bus.gate_i = i;
    bus.gate_g = g; bus.gate_o = o; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    edges = 0;
    k = 0;
    while (!bus.tanh_req && k < 20) begin step(); edges++; k++; end
    check("req_edge", edges, 2);
    check("tanh_operand", bus.tanh_operand, ce);
    op = bus.tanh_operand;
    if (early) begin
      bus.tanh_valid = 1'b1;
      bus.tanh_result = tv + 18'sd77;
    end
    step(); edges++;
    bus.tanh_valid = 1'b0;
    check("req_pulse", bus.tanh_req, 0);
    for (int n = 0; n < d; n++) begin
      check("op_hold", bus.tanh_operand, op);
      check("no_early_out", bus.out_valid, 0);
      step(); edges++;
    end
    bus.tanh_valid = 1'b1;
    bus.tanh_result = tv;
    step(); edges++;
    bus.tanh_valid = 1'b0;
    k = 0;
    while (!bus.out_valid && k < 20) begin step(); edges++; k++; end
    check("latency", edges, 5 + d);
    check("c_out", bus.c_out, ce);
    check("h_out", bus.h_out, he);
    check("busy_done", bus.busy, 1);
    for (int n = 0; n < bp; n++) begin
      bus.in_valid = 1'b1;
      step();
      check("bp_valid", bus.out_valid, 1);
      check("bp_ready", bus.in_ready, 0);
      check("bp_c", bus.c_out, ce);
      check("bp_h", bus.h_out, he);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    check("valid_drop", bus.out_valid, 0);
    check("back_idle", bus.in_ready, 1);
    check("c_hold", bus.c_out, ce);
    check("h_hold", bus.h_out, he);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.tanh_valid = 1'b0; bus.tanh_result = '0;
    bus.gate_i = '0; bus.gate_f = '0; bus.gate_g = '0;
    bus.gate_o = '0; bus.c_old = '0;
    step();
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_req", bus.tanh_req, 0);
    check("rst_operand", bus.tanh_operand, 0);
    check("rst_h", bus.h_out, 0);
    check("rst_c", bus.c_out, 0);
    reset = 1'b1;
    step();

    elem(1024, 2048, 1024, 1024, 2048, 1300, 0, 0, 0);
    check("basic_c", bus.c_out, 1536);
    check("basic_h", bus.h_out, 1300);

    elem(2048, -2048, 0, 0, 1024, -1560, 0, 0, 0);
    check("neg_c", bus.c_out, -2048);
    check("neg_h", bus.h_out, -780);

    elem(1024, 2048, 1024, 1024, 2048, 1300, 5, 1, 0);
    check("stall_c", bus.c_out, 1536);

    elem(2048, 122880, 2048, 20480, 2048, 500, 0, 0, 0);
`ifdef LSTM_CELL_SATURATE_EN
    check("ovf_c", bus.c_out, 131071);
`else
    check("ovf_c", bus.c_out, -118784);
`endif

    elem(-3000, 5000, 700, -900, 1500, -1200, 1, 0, 4);

    for (int n = 0; n < 24; n++) begin
      elem(18'($urandom), 18'($urandom), 18'($urandom),
           18'($urandom), 18'($urandom), 18'($urandom),
           int'($urandom_range(0, 3)), 1'($urandom),
           int'($urandom_range(0, 2)));
    end

    bus.gate_f = 1024; bus.c_old = 2048; bus.gate_i = 1024;
    bus.gate_g = 1024; bus.gate_o = 2048; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step(); step(); step();
    check("mid_busy", bus.busy, 1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("mid_in_ready", bus.in_ready, 1);
    check("mid_busy0", bus.busy, 0);
    check("mid_valid", bus.out_valid, 0);
    check("mid_req", bus.tanh_req, 0);
    check("mid_operand", bus.tanh_operand, 0);
    check("mid_h", bus.h_out, 0);
    check("mid_c", bus.c_out, 0);
    bus.tanh_valid = 1'b1;
    bus.tanh_result = 1300;
    step();
    bus.tanh_valid = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int n = 0; n < 10; n++) begin
        if (bus.out_valid) seen++;
        step();
      end
      check("mid_no_out", seen, 0);
    end
    check("mid_idle", bus.in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lstm_cell_update.md
Name: lstm_cell_update

Overview:
- Element-wise LSTM cell stage directly downstream of the gate activation units (sigmoid for i/f/o, tanh for g).
- Per neuron element, computes c_new = f*c_old + i*g. It sends c_new to an external tanh unit, then computes h = o*tanh(c_new).
- One shared 18x18 signed multiplier is used through a sequential FSM.
- Valid/ready handshakes on the input and output sides, and a req/valid handshake to the tanh unit.

Parameters:
- QN, 6, integer bits of the fixed-point format, excluding sign.
- QM, 11, fractional bits; word width W = QN+QM+1 = 18.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk while low.
- in_valid  input  1  i/f/g/o/c_old are valid.
- in_ready  output  1  high only in IDLE.
- gate_i, gate_f, gate_g, gate_o  input  W each  signed Q6.11 gate activations.
- c_old  input  W  signed Q6.11 previous cell state.
- tanh_req  output  1  one-cycle pulse requesting tanh(tanh_operand).
- tanh_operand  output  W  c_new; stable from TANH_REQ until tanh_valid is accepted.
- tanh_result  input  W  signed Q6.11 tanh value.
- tanh_valid  input  1  tanh_result is valid.
- out_valid  output  1  h_out and c_out are valid.
- out_ready  input  1  consumer accepts the output.
- h_out  output  W  signed Q6.11 hidden output.
- c_out  output  W  signed Q6.11 new cell state.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (reset low at an edge):
  - State goes to IDLE; all internal registers clear.
  - Outputs: in_ready=1, tanh_req=0, tanh_operand=0, out_valid=0, h_out=0, c_out=0, busy=0.
  - Reset mid-operation aborts the element; no partial result is emitted. A tanh_valid arriving after reset is ignored.
- Product rule: each product is 36-bit signed, arithmetically shifted right by QM (floor), then reduced to W bits (see Optional Feature). The sum f*c_old + i*g uses the same reduction.
- FSM states: IDLE, MUL_F, MUL_I, TANH_REQ, TANH_WAIT, MUL_O, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready, register all five inputs, then go to MUL_F.
- MUL_F: acc <= reduce((f*c_old)>>>QM); go to MUL_I.
- MUL_I: c_reg <= reduce(acc + reduce((i*g)>>>QM)); go to TANH_REQ.
- TANH_REQ: tanh_req=1 for exactly this cycle; tanh_operand=c_reg; go to TANH_WAIT. tanh_valid is ignored in this state.
- TANH_WAIT:
  - Holds until tanh_valid=1, then captures tanh_result and goes to MUL_O.
  - No timeout; tanh_operand is held for the whole wait.
- MUL_O: h_reg <= reduce((o*tanh_c)>>>QM); go to DONE.
- DONE:
  - out_valid=1; h_out=h_reg and c_out=c_reg, both stable.
  - On out_ready, go to IDLE; out_valid drops on the next cycle.
  - in_ready stays 0, so there is no same-cycle re-accept.
- Latency: with tanh_valid in the first TANH_WAIT cycle, out_valid is asserted in the 6th cycle after the accepting edge. Each additional tanh wait cycle adds one cycle.
- Throughput: one element per 7 cycles minimum, including IDLE.
- h_out and c_out keep their last values after the handshake completes, until the next DONE or reset.
- in_valid while busy is ignored; in_ready=0 exerts backpressure.

Optional Feature:
- Macro: LSTM_CELL_SATURATE_EN.
- Defined: every reduction to W bits saturates to +131071 / -131072 (Q6.11 max/min).
- Undefined: every reduction keeps the low W bits (two's-complement wrap).

Test Plan:
- Basic element: f=1024, c_old=2048, i=1024, g=1024, o=2048; tanh stub responds next cycle with 1300 -> tanh_operand=1536; c_out=1536, h_out=1300; out_valid in the 6th cycle after accept.
- Negative values: f=2048, c_old=-2048, i=0, g=0, o=1024; stub returns -1560 -> c_out=-2048, h_out=-780.
- Tanh stall: stub delays tanh_valid by 5 cycles -> tanh_req is a single pulse; tanh_operand is stable throughout; out_valid is 5 cycles later than the basic case; a tanh_valid driven during TANH_REQ is ignored.
- Overflow: f=2048, c_old=122880, i=2048, g=20480:
  - With LSTM_CELL_SATURATE_EN -> c_out=131071.
  - Without it -> c_out=-118784.
- Backpressure: hold out_ready=0 for 4 cycles in DONE -> out_valid, h_out, c_out stable; in_ready=0; a new in_valid is not accepted until after the handshake.
- Reset mid-op: drive reset low during TANH_WAIT -> next cycle is IDLE with all outputs at reset values; a later tanh_valid produces no out_valid.
